// File: rtl/quad_encoder_angle.sv
// Quadrature encoder front end: synchronize and filter A/B/Z, decode 4x steps, track
// electrical count with index reload, and convert it to a Q2.15 angle on request.
module quad_encoder_angle #(
  parameter int unsigned ECPR         = 1000,
  parameter int unsigned FILTER_LEN   = 4,
  parameter int unsigned INDEX_OFFSET = 0
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        enc_a,
  input  logic        enc_b,
  input  logic        enc_z,
  input  logic        sample,
  input  logic        err_clr,
  output logic [17:0] theta_tdata,
  output logic        theta_tvalid,
  output logic [31:0] pos_count,
  output logic        dir,
  output logic        index_seen,
  output logic        err
);

  localparam int unsigned CW          = $clog2(FILTER_LEN + 1);
  localparam logic [CW-1:0] FL_C      = CW'(FILTER_LEN);
  localparam logic [63:0] TWO_PI_Q31  = 64'd13493037704;
  localparam logic [47:0] K_C         = 48'(TWO_PI_Q31 / 64'(ECPR));
  localparam logic [17:0] PI_Q15      = 18'd102943;
  localparam logic [15:0] ECNT_MAX    = 16'(ECPR - 1);
  localparam logic [15:0] ECNT_RST    = 16'(INDEX_OFFSET);

  // Line index 0 = A, 1 = B, 2 = Z.
  logic [2:0]    sync1_q, sync2_q, last_q, last_d;
  logic [2:0]    filt_q, filt_d, fvalid_q, fvalid_d;
  logic [CW-1:0] cnt_q [3];
  logic [CW-1:0] cnt_d [3];

  logic [1:0]  ab_prev_q, ab_prev_d, ab_cur;
  logic        ab_primed_q, ab_primed_d, ab_valid;
  logic        z_prev_q, z_prev_d, z_primed_q, z_primed_d, z_rise;
  logic        step_up, step_dn, illegal;

  logic [31:0] pos_q, pos_d;
  logic [15:0] ecnt_q, ecnt_d;
  logic        dir_q, dir_d, index_q, index_d, err_q, err_d;

  logic [15:0] snap_q, snap_d;
  logic [17:0] scaled_q, scaled_d;
  logic [17:0] theta_q, theta_d;
  logic        v1_q, v2_q, tvalid_q;

  function automatic logic [1:0] gray_pos(input logic [1:0] ab);
    logic [1:0] p;
    unique case (ab)
      2'b00:   p = 2'd0;
      2'b01:   p = 2'd1;
      2'b11:   p = 2'd2;
      default: p = 2'd3;
    endcase
    return p;
  endfunction

  // A level is accepted once the same synchronized value has been seen FILTER_LEN times.
  always_comb begin
    last_d   = sync2_q;
    filt_d   = filt_q;
    fvalid_d = fvalid_q;
    for (int i = 0; i < 3; i++) begin
      if (cnt_q[i] == '0 || sync2_q[i] != last_q[i]) begin
        cnt_d[i] = CW'(1);
      end else if (cnt_q[i] < FL_C) begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end else begin
        cnt_d[i] = cnt_q[i];
      end
      if (cnt_d[i] >= FL_C) begin
        filt_d[i]   = sync2_q[i];
        fvalid_d[i] = 1'b1;
      end
    end
  end

  always_comb begin
    ab_cur      = {filt_q[0], filt_q[1]};
    ab_valid    = fvalid_q[0] & fvalid_q[1];
    ab_prev_d   = ab_valid ? ab_cur : ab_prev_q;
    ab_primed_d = ab_primed_q | ab_valid;
    step_up     = 1'b0;
    step_dn     = 1'b0;
    illegal     = 1'b0;
    if (ab_primed_q && ab_cur != ab_prev_q) begin
      if (ab_cur == ~ab_prev_q) begin
        illegal = 1'b1;
      end else if (gray_pos(ab_cur) == gray_pos(ab_prev_q) + 2'd1) begin
        step_dn = 1'b1;
      end else begin
        step_up = 1'b1;
      end
    end

    z_prev_d   = fvalid_q[2] ? filt_q[2] : z_prev_q;
    z_primed_d = z_primed_q | fvalid_q[2];
    z_rise     = z_primed_q & filt_q[2] & ~z_prev_q;
  end

  always_comb begin
    pos_d   = pos_q;
    ecnt_d  = ecnt_q;
    dir_d   = dir_q;
    index_d = index_q;
    err_d   = err_q;
    if (step_up) begin
      pos_d  = pos_q + 32'd1;
      ecnt_d = (ecnt_q == ECNT_MAX) ? 16'd0 : ecnt_q + 16'd1;
      dir_d  = 1'b1;
    end else if (step_dn) begin
      pos_d  = pos_q - 32'd1;
      ecnt_d = (ecnt_q == 16'd0) ? ECNT_MAX : ecnt_q - 16'd1;
      dir_d  = 1'b0;
    end
    // Index reload overrides any coincident step on the electrical count only.
    if (z_rise) begin
      ecnt_d  = ECNT_RST;
      index_d = 1'b1;
    end
    if (err_clr) begin
      err_d = 1'b0;
    end
    if (illegal) begin
      err_d = 1'b1;
    end
  end

  // Angle pipeline: snapshot, scale, offset.
  always_comb begin
    snap_d   = sample ? ecnt_q : snap_q;
    scaled_d = v1_q ? 18'(({32'd0, snap_q} * K_C) >> 16) : scaled_q;
    theta_d  = v2_q ? (scaled_q - PI_Q15) : theta_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      last_q      <= '0;
      filt_q      <= '0;
      fvalid_q    <= '0;
      for (int i = 0; i < 3; i++) begin
        cnt_q[i] <= '0;
      end
      ab_prev_q   <= '0;
      ab_primed_q <= 1'b0;
      z_prev_q    <= 1'b0;
      z_primed_q  <= 1'b0;
      pos_q       <= '0;
      ecnt_q      <= ECNT_RST;
      dir_q       <= 1'b0;
      index_q     <= 1'b0;
      err_q       <= 1'b0;
      snap_q      <= '0;
      scaled_q    <= '0;
      theta_q     <= '0;
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      tvalid_q    <= 1'b0;
    end else begin
      sync1_q     <= {enc_z, enc_b, enc_a};
      sync2_q     <= sync1_q;
      last_q      <= last_d;
      filt_q      <= filt_d;
      fvalid_q    <= fvalid_d;
      for (int i = 0; i < 3; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      ab_prev_q   <= ab_prev_d;
      ab_primed_q <= ab_primed_d;
      z_prev_q    <= z_prev_d;
      z_primed_q  <= z_primed_d;
      pos_q       <= pos_d;
      ecnt_q      <= ecnt_d;
      dir_q       <= dir_d;
      index_q     <= index_d;
      err_q       <= err_d;
      snap_q      <= snap_d;
      scaled_q    <= scaled_d;
      theta_q     <= theta_d;
      v1_q        <= sample;
      v2_q        <= v1_q;
      tvalid_q    <= v2_q;
    end
  end

  assign theta_tdata  = theta_q;
  assign theta_tvalid = tvalid_q;
  assign pos_count    = pos_q;
  assign dir          = dir_q;
  assign index_seen   = index_q;
  assign err          = err_q;

endmodule
